// File: rtl/pc_sequencer.sv
// Program-counter sequencer: PC register, next-PC select, fetch handshake and one-cycle flush after redirects.
// Optional taken-redirect statistics counter is compiled in with `define BRANCH_STATS_EN.
module pc_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        instr_valid,
   input  logic        stall,
   input  logic        branch_eq,
   input  logic        branch_ne,
   input  logic        zero,
   input  logic        jump,
   input  logic        jump_reg,
   input  logic [31:0] imm_ext,
   input  logic [25:0] jump_index,
   input  logic [31:0] rs_value,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        fetch_req,
   output logic        flush,
   output logic        redirect_taken,
`ifdef BRANCH_STATS_EN
   output logic [15:0] branch_count,
`endif
   output logic [1:0]  fsm_state
);

   // Handshake: an instruction at pc is accepted in FETCH on a rising edge where
   // instr_valid=1 and stall=0; otherwise pc holds and decode inputs are ignored.
   typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, FLUSH = 2'd2} state_t;

   state_t      state;
   logic [31:0] br_tgt;
   logic [31:0] j_tgt;
   logic [31:0] jr_tgt;
   logic [31:0] target;
   logic        br_take;
   logic        redirect;
   logic        accept;
   logic        unused_bits;

   assign pc_plus4 = pc + 32'd4;
   assign br_tgt   = pc_plus4 + {imm_ext[29:0], 2'b00};
   assign j_tgt    = {pc_plus4[31:28], jump_index, 2'b00};
   assign jr_tgt   = {rs_value[31:2], 2'b00};

   // Both branch strobes high is an illegal encoding and falls through sequentially.
   assign br_take  = (branch_eq ^ branch_ne) & ((branch_eq & zero) | (branch_ne & ~zero));
   assign redirect = jump_reg | jump | br_take;
   assign accept   = instr_valid & ~stall;

   always_comb begin
      target = pc_plus4;
      if (jump_reg)     target = jr_tgt;
      else if (jump)    target = j_tgt;
      else if (br_take) target = br_tgt;
   end

   assign fsm_state   = state;
   assign unused_bits = ^{imm_ext[31:30], rs_value[1:0]};

`ifdef BRANCH_STATS_EN
   logic [15:0] branch_cnt_q;
   assign branch_count = branch_cnt_q;

   always_ff @(posedge clk) begin
      if (!reset_n)
         branch_cnt_q <= 16'd0;
      else if (state == FETCH && accept && redirect && branch_cnt_q != 16'hFFFF)
         branch_cnt_q <= branch_cnt_q + 16'd1;
   end
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pc             <= RESET_PC;
         state          <= IDLE;
         fetch_req      <= 1'b0;
         flush          <= 1'b0;
         redirect_taken <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               state          <= FETCH;
               fetch_req      <= 1'b1;
               flush          <= 1'b0;
               redirect_taken <= 1'b0;
            end
            FETCH: begin
               redirect_taken <= 1'b0;
               if (accept) begin
                  if (redirect) begin
                     pc             <= target;
                     state          <= FLUSH;
                     fetch_req      <= 1'b0;
                     flush          <= 1'b1;
                     redirect_taken <= 1'b1;
                  end else begin
                     pc <= pc_plus4;
                  end
               end
            end
            FLUSH: begin
               state          <= FETCH;
               fetch_req      <= 1'b1;
               flush          <= 1'b0;
               redirect_taken <= 1'b0;
            end
            default: begin
               state          <= IDLE;
               fetch_req      <= 1'b0;
               flush          <= 1'b0;
               redirect_taken <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the single-cycle datapath. Holds the PC register, selects the next PC and fetches through a small valid/stall handshake with instruction memory. Next-PC sources are sequential (PC+4), conditional branch (PC+4 plus word offset shifted left 2), jump (pseudo-direct) and jump-register. Any taken redirect inserts a one-cycle flush bubble. It sits between the control unit / ALU zero flag and the instruction memory address port.

## Interface
Parameters
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.

Ports
- clk  in  1  rising-edge clock.
- reset_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- instr_valid  in  1  instruction memory has a valid instruction for the current pc.
- stall  in  1  hazard hold from the control unit; freezes the PC.
- branch_eq  in  1  decoded beq.
- branch_ne  in  1  decoded bne.
- zero  in  1  ALU zero flag for the current instruction.
- jump  in  1  decoded j/jal.
- jump_reg  in  1  decoded jr.
- imm_ext  in  32  sign-extended 16-bit branch offset, in words.
- jump_index  in  26  instruction [25:0].
- rs_value  in  32  register rs, the jr target.
- pc  out  32  current PC, the instruction memory address.
- pc_plus4  out  32  pc + 4, combinational.
- fetch_req  out  1  high when pc is a live fetch address.
- flush  out  1  the instruction at pc is squashed; no state update is allowed downstream.
- redirect_taken  out  1  one-cycle pulse, registered, on the cycle after a redirect is accepted.
- branch_count  out  16  count of taken branches and jumps; present only with BRANCH_STATS_EN.

## Operation
- Target arithmetic, all modulo 2^32 with carries out of bit 31 discarded:
  - br_tgt = pc_plus4 + {imm_ext[29:0], 2'b00}.
  - j_tgt = {pc_plus4[31:28], jump_index, 2'b00}.
  - jr_tgt = {rs_value[31:2], 2'b00}.
- Taken conditions:
  - br_take = (branch_eq & zero) ^ (branch_ne & ~zero), evaluated only when exactly one of branch_eq / branch_ne is high.
  - If branch_eq and branch_ne are both high, the encoding is illegal: no branch, sequential flow.
- Priority: jump_reg > jump > br_take > sequential.
- FSM states:
  - IDLE: entered on reset. fetch_req=0, flush=0. Always goes to FETCH on the next cycle.
  - FETCH: fetch_req=1. An instruction is accepted when instr_valid=1 and stall=0.
    - No redirect: pc <= pc_plus4 and the FSM stays in FETCH.
    - Redirect: pc <= selected target and the FSM goes to FLUSH.
    - instr_valid=0 or stall=1: pc holds, the FSM stays in FETCH, and all decode inputs are ignored.
  - FLUSH: fetch_req=0, flush=1, redirect_taken=1. pc holds the target. Always goes to FETCH on the next cycle; stall and instr_valid are ignored in this state.
- Stall has precedence over redirect: a branch seen during a stall is not taken, and the decoder re-presents it.
- Reset mid-operation, in any state: on the next edge with reset_n=0, pc <= RESET_PC, state <= IDLE, all pulses clear, and any pending redirect is discarded.

## Timing
- Reset values: pc=RESET_PC, fetch_req=0, flush=0, redirect_taken=0, branch_count=0.
- pc, the FSM state and redirect_taken are registered. pc_plus4 is combinational from pc. fetch_req and flush are decoded from the state only, with no input-to-output combinational path.
- Sequential throughput: one instruction per cycle while instr_valid=1 and stall=0.
- Redirect latency: the decision is made in cycle N. In N+1, pc=target and the FSM is in FLUSH. In N+2, the target is fetched. A taken redirect therefore costs 1 bubble cycle.
- Back-to-back redirects cannot occur, because FLUSH never accepts an instruction.

## Configuration
- BRANCH_STATS_EN defined:
  - branch_count is a 16-bit counter that increments at each accepted redirect (branch, j or jr).
  - It saturates at 16'hFFFF and clears on reset.
- BRANCH_STATS_EN undefined: the branch_count port and its counter are not compiled. All other behaviour is identical.

## Test plan
- Reset then sequential flow:
  - Stimulus: RESET_PC=0; release reset_n; hold instr_valid=1.
  - Response: IDLE for 1 cycle, then pc=0x0, 0x4, 0x8, 0xC on successive cycles with fetch_req=1.
- Taken beq:
  - Stimulus: at pc=0x100, branch_eq=1, zero=1, imm_ext=32'hFFFF_FFFC.
  - Response: next pc=0x0F4, flush=1 and redirect_taken=1 for one cycle, then a fetch at 0x0F4.
- Untaken bne plus illegal encoding:
  - bne with zero=1 gives pc=0x104.
  - branch_eq=branch_ne=1 gives pc=0x104 with no flush.
- Jump and jr priority:
  - Stimulus: at pc=0x3000_0010, jump=1, jump_index=26'h10, jump_reg=1, rs_value=0x0000_2003.
  - Response: pc=0x0000_2000, because jr wins.
  - With jump_reg=0, the same stimulus gives pc=0x3000_0040.
- Stall versus branch, and reset mid-FLUSH:
  - A taken branch with stall=1 for 3 cycles holds pc and gives no flush; the redirect happens when stall drops.
  - Asserting reset_n=0 during FLUSH gives pc=RESET_PC, state IDLE, and redirect_taken=0 on the next edge.
- BRANCH_STATS_EN:
  - 5 taken redirects give branch_count=5.
  - Forcing the counter to 16'hFFFE and then taking 3 redirects gives a saturated 16'hFFFF.
